// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared response and the shared-ALU
// connection for alu_arbiter. The arbiter takes the slave side; the requesters
// and the combinational ALU take the master side.
interface alu_arbiter_if #(
  parameter int unsigned W = 32
);
  // Requester A
  logic         a_valid;
  logic [2:0]   a_op;
  logic [W-1:0] a_in1;
  logic [W-1:0] a_in2;
  logic         a_ready;
  logic         a_rsp_valid;
  logic         a_rsp_ready;

  // Requester B
  logic         b_valid;
  logic [2:0]   b_op;
  logic [W-1:0] b_in1;
  logic [W-1:0] b_in2;
  logic         b_ready;
  logic         b_rsp_valid;
  logic         b_rsp_ready;

  // Shared response
  logic [W-1:0] rsp_out;
  logic         rsp_zero;

  // Shared ALU
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_out;
  logic         alu_zero;

  logic         busy;

  modport slave (
    input  a_valid, a_op, a_in1, a_in2, a_rsp_ready,
    input  b_valid, b_op, b_in1, b_in2, b_rsp_ready,
    input  alu_out, alu_zero,
    output a_ready, a_rsp_valid,
    output b_ready, b_rsp_valid,
    output rsp_out, rsp_zero,
    output alu_in1, alu_in2, alu_ctrl,
    output busy
  );

  modport master (
    output a_valid, a_op, a_in1, a_in2, a_rsp_ready,
    output b_valid, b_op, b_in1, b_in2, b_rsp_ready,
    output alu_out, alu_zero,
    input  a_ready, a_rsp_valid,
    input  b_ready, b_rsp_valid,
    input  rsp_out, rsp_zero,
    input  alu_in1, alu_in2, alu_ctrl,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared combinational
// ALU. One operation is in flight at a time: IDLE grants and latches operands,
// ISSUE lets the ALU settle, CAPTURE registers its result, RESP holds the
// result until the granted requester takes it.
module alu_arbiter #(
  parameter int unsigned W = 32
) (
  input logic        i_clk,
  input logic        i_rst,
  alu_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StResp    = 2'd3
  } state_e;

  state_e       r_state;
  state_e       w_state_next;

  logic         r_prio_b;   // B wins a tie when set
  logic         r_gnt_b;    // requester owning the operation in flight
  logic [W-1:0] r_alu_in1;
  logic [W-1:0] r_alu_in2;
  logic [2:0]   r_alu_ctrl;
  logic [W-1:0] r_rsp_out;
  logic         r_rsp_zero;

  logic         w_grant;
  logic         w_grant_b;
  logic         w_a_ready;
  logic         w_b_ready;
  logic         w_a_rsp_valid;
  logic         w_b_rsp_valid;
  logic         w_busy;
  logic         w_rsp_ready;
  logic         w_rsp_done;
  logic [2:0]   w_op_sel;
  logic [2:0]   w_ctrl_sel;
  logic [W-1:0] w_in1_sel;
  logic [W-1:0] w_in2_sel;

  // Only the owner's consumer handshake can close a response.
  assign w_rsp_ready = r_gnt_b ? io_bus.b_rsp_ready : io_bus.a_rsp_ready;
  assign w_rsp_done  = (r_state == StResp) && w_rsp_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: fixed ISSUE/CAPTURE steps, RESP waits for the owner's ready
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (io_bus.a_valid || io_bus.b_valid) w_state_next = StIssue;
      StIssue:   w_state_next = StCapture;
      StCapture: w_state_next = StResp;
      StResp:    if (w_rsp_ready) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Outputs: round-robin grant, ready pulses, response valids and busy
  always_comb begin
    w_grant   = 1'b0;
    w_grant_b = 1'b0;
    // No grant while reset is held, so a requester never sees a ready that is
    // about to be discarded.
    if ((r_state == StIdle) && !i_rst) begin
      if (io_bus.a_valid && io_bus.b_valid) begin
        w_grant   = 1'b1;
        w_grant_b = r_prio_b;
      end else if (io_bus.a_valid) begin
        w_grant   = 1'b1;
        w_grant_b = 1'b0;
      end else if (io_bus.b_valid) begin
        w_grant   = 1'b1;
        w_grant_b = 1'b1;
      end
    end
    w_a_ready     = w_grant && !w_grant_b;
    w_b_ready     = w_grant && w_grant_b;
    w_a_rsp_valid = (r_state == StResp) && !r_gnt_b;
    w_b_rsp_valid = (r_state == StResp) && r_gnt_b;
    w_busy        = (r_state != StIdle);
  end

  // Select the granted requester's op/operands; store-address (010) reuses add (001)
  always_comb begin
    w_op_sel   = w_grant_b ? io_bus.b_op  : io_bus.a_op;
    w_in1_sel  = w_grant_b ? io_bus.b_in1 : io_bus.a_in1;
    w_in2_sel  = w_grant_b ? io_bus.b_in2 : io_bus.a_in2;
    w_ctrl_sel = (w_op_sel == 3'b010) ? 3'b001 : w_op_sel;
  end

  // Operand latch at grant, result capture, and pointer update at completion
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio_b   <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_alu_in1  <= '0;
      r_alu_in2  <= '0;
      r_alu_ctrl <= 3'b000;
      r_rsp_out  <= '0;
      r_rsp_zero <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt_b    <= w_grant_b;
        r_alu_ctrl <= w_ctrl_sel;
        r_alu_in1  <= w_in1_sel;
        r_alu_in2  <= w_in2_sel;
      end
      if (r_state == StCapture) begin
        r_rsp_out  <= io_bus.alu_out;
        r_rsp_zero <= io_bus.alu_zero;
      end
      if (w_rsp_done) begin
        r_prio_b <= ~r_gnt_b;
      end
    end
  end

  assign io_bus.a_ready     = w_a_ready;
  assign io_bus.b_ready     = w_b_ready;
  assign io_bus.a_rsp_valid = w_a_rsp_valid;
  assign io_bus.b_rsp_valid = w_b_rsp_valid;
  assign io_bus.rsp_out     = r_rsp_out;
  assign io_bus.rsp_zero    = r_rsp_zero;
  assign io_bus.alu_in1     = r_alu_in1;
  assign io_bus.alu_in2     = r_alu_in2;
  assign io_bus.alu_ctrl    = r_alu_ctrl;
  assign io_bus.busy        = w_busy;

  // Structural invariants of the handshake
  a_ready_excl : assert property (@(posedge i_clk) !(w_a_ready && w_b_ready));
  a_rsp_excl   : assert property (@(posedge i_clk) !(w_a_rsp_valid && w_b_rsp_valid));
  a_rsp_stable : assert property (@(posedge i_clk) disable iff (i_rst)
                   ((r_state == StResp) && !w_rsp_ready) |=> $stable(r_rsp_out));
  a_ops_stable : assert property (@(posedge i_clk) disable iff (i_rst)
                   (r_state == StIssue) |=> ($stable(r_alu_in1) && $stable(r_alu_ctrl)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a table of single-requester vectors with latency
// checks, hand sequences for arbitration, stalls and mid-operation reset, and
// a scoreboard that predicts every accepted request's response.
module tb_alu_arbiter;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W)) u_if ();

  alu_arbiter #(.W(W)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (u_if)
  );

  // Reference ALU; 010 returns a marker so an unmapped store-address shows up
  function automatic logic [W-1:0] alu_fn(input logic [2:0] c, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (c)
      3'b000, 3'b001: alu_fn = x + y;
      3'b010:         alu_fn = 32'hDEAD_BEEF;
      3'b011:         alu_fn = x ^ y;
      3'b100:         alu_fn = x & y;
      3'b101:         alu_fn = x | y;
      3'b110:         alu_fn = x - y;
      default:        alu_fn = (x < y) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] ctrl_fn(input logic [2:0] op);
    ctrl_fn = (op == 3'b010) ? 3'b001 : op;
  endfunction

  assign u_if.alu_out  = alu_fn(u_if.alu_ctrl, u_if.alu_in1, u_if.alu_in2);
  assign u_if.alu_zero = (alu_fn(u_if.alu_ctrl, u_if.alu_in1, u_if.alu_in2) == '0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic         is_b;
    logic [W-1:0] out;
    logic         zero;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t predict(input logic is_b, input logic [2:0] op,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.is_b = is_b;
    e.out  = alu_fn(ctrl_fn(op), x, y);
    e.zero = (e.out == '0);
    return e;
  endfunction

  task automatic sb_pop(input logic is_b);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_owner", is_b, e.is_b);
      chk("sb_rsp_out", u_if.rsp_out, e.out);
      chk("sb_rsp_zero", u_if.rsp_zero, e.zero);
    end
  endtask

  // Monitor: push on accept, pop on response handshake; reset aborts in-flight work
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      chk("ready_excl", u_if.a_ready & u_if.b_ready, 32'd0);
      chk("rsp_valid_excl", u_if.a_rsp_valid & u_if.b_rsp_valid, 32'd0);
      if (u_if.a_ready) sb.push_back(predict(1'b0, u_if.a_op, u_if.a_in1, u_if.a_in2));
      if (u_if.b_ready) sb.push_back(predict(1'b1, u_if.b_op, u_if.b_in1, u_if.b_in2));
      if (u_if.a_rsp_valid && u_if.a_rsp_ready) sb_pop(1'b0);
      if (u_if.b_rsp_valid && u_if.b_rsp_ready) sb_pop(1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic is_b, input logic v, input logic [2:0] op,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    if (is_b) begin
      u_if.b_valid = v; u_if.b_op = op; u_if.b_in1 = x; u_if.b_in2 = y;
    end else begin
      u_if.a_valid = v; u_if.a_op = op; u_if.a_in1 = x; u_if.a_in2 = y;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (u_if.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", u_if.busy, 32'd0);
  endtask

  task automatic check_zero(input string tag, input logic exp_a_ready);
    chk({tag, "_a_ready"}, u_if.a_ready, exp_a_ready);
    chk({tag, "_b_ready"}, u_if.b_ready, 32'd0);
    chk({tag, "_a_rsp_valid"}, u_if.a_rsp_valid, 32'd0);
    chk({tag, "_b_rsp_valid"}, u_if.b_rsp_valid, 32'd0);
    chk({tag, "_rsp_out"}, u_if.rsp_out, 32'd0);
    chk({tag, "_rsp_zero"}, u_if.rsp_zero, 32'd0);
    chk({tag, "_alu_in1"}, u_if.alu_in1, 32'd0);
    chk({tag, "_alu_in2"}, u_if.alu_in2, 32'd0);
    chk({tag, "_alu_ctrl"}, u_if.alu_ctrl, 32'd0);
    chk({tag, "_busy"}, u_if.busy, 32'd0);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check_zero("rst", 1'b0);
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic         is_b;
    logic [2:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [2:0]   ctrl;
    logic [W-1:0] out;
    logic         zero;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 3'b000, 32'd5,         32'd7,         3'b000, 32'd12,        1'b0};
    tbl[1] = '{1'b1, 3'b010, 32'h100,       32'd4,         3'b001, 32'h104,       1'b0};
    tbl[2] = '{1'b0, 3'b001, 32'd10,        32'hFFFF_FFF6, 3'b001, 32'd0,         1'b1};
    tbl[3] = '{1'b1, 3'b011, 32'h0000_F0F0, 32'h0000_0FF0, 3'b011, 32'h0000_FF00, 1'b0};
    tbl[4] = '{1'b0, 3'b100, 32'hFF00_FF00, 32'h0F0F_0F0F, 3'b100, 32'h0F00_0F00, 1'b0};
    tbl[5] = '{1'b1, 3'b101, 32'd1,         32'd2,         3'b101, 32'd3,         1'b0};
    tbl[6] = '{1'b0, 3'b110, 32'd3,         32'd5,         3'b110, 32'hFFFF_FFFE, 1'b0};
    tbl[7] = '{1'b1, 3'b111, 32'd7,         32'd2,         3'b111, 32'd0,         1'b1};

    drive(1'b0, 1'b0, 3'b000, '0, '0);
    drive(1'b1, 1'b0, 3'b000, '0, '0);
    u_if.a_rsp_ready = 1'b1;
    u_if.b_rsp_ready = 1'b1;

    do_reset();
    @(negedge clk);
    check_zero("post_rst", 1'b0);

    // Single-requester vectors with the T / T+1 / T+3 timing checks
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      cyc();
      drive(tbl[i].is_b, 1'b1, tbl[i].op, tbl[i].in1, tbl[i].in2);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), tbl[i].is_b ? u_if.b_ready : u_if.a_ready, 32'd1);
      cyc();
      drive(tbl[i].is_b, 1'b0, 3'b000, '0, '0);
      @(negedge clk);
      chk($sformatf("v%0d_alu_ctrl", i), u_if.alu_ctrl, tbl[i].ctrl);
      chk($sformatf("v%0d_alu_in1", i), u_if.alu_in1, tbl[i].in1);
      chk($sformatf("v%0d_alu_in2", i), u_if.alu_in2, tbl[i].in2);
      chk($sformatf("v%0d_busy", i), u_if.busy, 32'd1);
      cyc();
      @(negedge clk);
      chk($sformatf("v%0d_early_rsp", i), u_if.a_rsp_valid | u_if.b_rsp_valid, 32'd0);
      cyc();
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i),
          tbl[i].is_b ? u_if.b_rsp_valid : u_if.a_rsp_valid, 32'd1);
      chk($sformatf("v%0d_rsp_out", i), u_if.rsp_out, tbl[i].out);
      chk($sformatf("v%0d_rsp_zero", i), u_if.rsp_zero, tbl[i].zero);
    end

    // Both valid from reset: A first, then B after A's handshake
    wait_idle();
    do_reset();
    drive(1'b0, 1'b1, 3'b110, 32'd9, 32'd9);
    drive(1'b1, 1'b1, 3'b111, 32'd3, 32'd4);
    @(negedge clk);
    chk("tie_a_ready", u_if.a_ready, 32'd1);
    chk("tie_b_ready", u_if.b_ready, 32'd0);
    cyc();
    u_if.a_valid = 1'b0;
    @(negedge clk);
    chk("tie_ctrl_a", u_if.alu_ctrl, 32'd6);
    cyc();
    cyc();
    @(negedge clk);
    chk("tie_a_rsp_valid", u_if.a_rsp_valid, 32'd1);
    chk("tie_a_rsp_out", u_if.rsp_out, 32'd0);
    chk("tie_a_rsp_zero", u_if.rsp_zero, 32'd1);
    cyc();
    @(negedge clk);
    chk("tie_b_ready_next", u_if.b_ready, 32'd1);
    cyc();
    u_if.b_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("tie_b_rsp_valid", u_if.b_rsp_valid, 32'd1);
    chk("tie_b_rsp_out", u_if.rsp_out, 32'd1);
    chk("tie_b_rsp_zero", u_if.rsp_zero, 32'd0);

    // Continuous contention: grants alternate A,B,A,B every 4 cycles
    wait_idle();
    cyc();
    drive(1'b0, 1'b1, 3'b000, 32'd20, 32'd22);
    drive(1'b1, 1'b1, 3'b011, 32'hAA, 32'h55);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_a_ready", i), u_if.a_ready, (i % 8 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_b_ready", i), u_if.b_ready, (i % 8 == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    u_if.a_valid = 1'b0;
    u_if.b_valid = 1'b0;

    // Response stall on A: result held, B locked out, B's rsp_ready ignored
    wait_idle();
    cyc();
    u_if.a_rsp_ready = 1'b0;
    u_if.b_rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 3'b000, 32'h11, 32'h22);
    drive(1'b1, 1'b1, 3'b000, 32'd1, 32'd1);
    @(negedge clk);
    chk("stall_a_ready", u_if.a_ready, 32'd1);
    cyc();
    u_if.a_valid = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("stall%0d_a_rsp_valid", k), u_if.a_rsp_valid, 32'd1);
      chk($sformatf("stall%0d_rsp_out", k), u_if.rsp_out, 32'h33);
      chk($sformatf("stall%0d_b_ready", k), u_if.b_ready, 32'd0);
      chk($sformatf("stall%0d_b_rsp_valid", k), u_if.b_rsp_valid, 32'd0);
    end
    cyc();
    u_if.a_rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", u_if.a_rsp_valid, 32'd1);
    cyc();
    @(negedge clk);
    chk("stall_b_granted", u_if.b_ready, 32'd1);
    chk("stall_a_rsp_dropped", u_if.a_rsp_valid, 32'd0);
    cyc();
    u_if.b_valid = 1'b0;

    // Reset during CAPTURE aborts the op; pending A is granted right after
    wait_idle();
    cyc();
    drive(1'b0, 1'b1, 3'b000, 32'd1, 32'd2);
    @(negedge clk);
    chk("abort_a_ready", u_if.a_ready, 32'd1);
    cyc();
    u_if.a_valid = 1'b0;
    cyc();
    rst = 1'b1;
    drive(1'b0, 1'b1, 3'b100, 32'd6, 32'd3);
    @(negedge clk);
    chk("abort_no_ready", u_if.a_ready, 32'd0);
    chk("abort_busy", u_if.busy, 32'd1);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check_zero("abort", 1'b1);
    cyc();
    u_if.a_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("abort_rsp_valid", u_if.a_rsp_valid, 32'd1);
    chk("abort_rsp_out", u_if.rsp_out, 32'd2);
    chk("abort_alu_ctrl", u_if.alu_ctrl, 32'd4);

    wait_idle();
    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
